// File: rtl/delay_timer_periodic.sv
// Delay timer counting in units of TICK_PERIOD enabled cycles, with one-shot
// or auto-reload (periodic) operation and a registered completion strobe.
module delay_timer_periodic #(
  parameter int TICK_PERIOD = 500000,
  parameter int TICK_W      = 19,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             periodic,
  input  logic [CNT_W-1:0] delay,
  output logic             done,
  output logic             done_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_PERIOD - 1);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  reload_q, reload_d;
  logic              mode_q, mode_d;
  logic              pulse_q, pulse_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      pulse_q  <= pulse_d;
    end
  end

  // Priority is start, then stop, then the prescaler tick; a start always
  // discards whatever the running interval was about to produce.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    pulse_d  = 1'b0;

    if (start) begin
      presc_d = '0;
      if (delay != '0) begin
        cnt_d    = delay;
        reload_d = delay;
        mode_d   = periodic;
        state_d  = RUN;
      end else begin
        cnt_d   = '0;
        state_d = DONE;
        pulse_d = 1'b1;
      end
    end else if (stop) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = '0;
    end else if (state_q == RUN && enable) begin
      if (presc_q == TICK_MAX) begin
        presc_d = '0;
        // Counter never goes below zero; the last unit either reloads or ends.
        if (cnt_q <= CNT_W'(1)) begin
          pulse_d = 1'b1;
          if (mode_q) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else begin
        presc_d = presc_q + TICK_W'(1);
      end
    end
  end

  assign done       = (state_q != RUN);
  assign busy       = (state_q == RUN);
  assign done_pulse = pulse_q;
  assign remaining  = cnt_q;

endmodule

// File: tb/tb_delay_timer_periodic.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// an elapsed-cycle arithmetic model of the delay timer.
module tb_delay_timer_periodic;

  localparam int T  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, enable, periodic;
  logic [CW-1:0] delay;
  logic          done, done_pulse, busy;
  logic [CW-1:0] remaining;

  int checks = 0;
  int errors = 0;

  delay_timer_periodic #(
    .TICK_PERIOD(T),
    .TICK_W(3),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .enable(enable),
    .periodic(periodic),
    .delay(delay),
    .done(done),
    .done_pulse(done_pulse),
    .busy(busy),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Reference: remaining time derives from enabled cycles elapsed since load
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t m_state;
  longint  m_elapsed;
  int      m_delay;
  bit      m_per;
  bit      m_pulse;

  int edge_count  = 0;
  int pulse_count = 0;
  int last_pulse  = -1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int modelRemaining();
    if (m_state != M_RUN) return 0;
    return m_delay - int'((m_elapsed % longint'(m_delay * T)) / T);
  endfunction

  task automatic modelReset();
    m_state   = M_IDLE;
    m_elapsed = 0;
    m_delay   = 0;
    m_per     = 1'b0;
    m_pulse   = 1'b0;
  endtask

  task automatic modelStep();
    if (!reset_n) begin
      modelReset();
      return;
    end
    m_pulse = 1'b0;
    if (start) begin
      if (delay != 0) begin
        m_state   = M_RUN;
        m_delay   = int'(delay);
        m_per     = periodic;
        m_elapsed = 0;
      end else begin
        m_state = M_DONE;
        m_pulse = 1'b1;
      end
    end else if (stop) begin
      m_state   = M_IDLE;
      m_elapsed = 0;
    end else if (m_state == M_RUN && enable) begin
      m_elapsed++;
      if (m_elapsed % longint'(m_delay * T) == 0) begin
        m_pulse = 1'b1;
        if (!m_per) m_state = M_DONE;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".done"},   32'(done),       32'(m_state != M_RUN));
    checkOutput({tag, ".busy"},   32'(busy),       32'(m_state == M_RUN));
    checkOutput({tag, ".pulse"},  32'(done_pulse), 32'(m_pulse));
    checkOutput({tag, ".remain"}, 32'(remaining),  32'(modelRemaining()));
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelStep();
    edge_count++;
    @(negedge clk);
    if (done_pulse === 1'b1) begin
      pulse_count++;
      last_pulse = edge_count;
    end
    checkAll(tag);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit en, input bit per,
                               input int dly, input int n, input string tag);
    start    = st;
    stop     = sp;
    enable   = en;
    periodic = per;
    delay    = CW'(dly);
    stepCycle(tag);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 1; i < n; i++) stepCycle(tag);
  endtask

  initial begin
    int k;
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    enable   = 1'b1;
    periodic = 1'b0;
    delay    = '0;
    modelReset();
    #12;
    checkAll("reset");
    #10 reset_n = 1'b1;
    applyStimulus(0, 0, 1, 0, 7, 2, "post_reset");

    // One-shot, delay 3: completion 12 edges after start
    pulse_count = 0;
    applyStimulus(1, 0, 1, 0, 3, 1, "os_start");
    k = edge_count;
    applyStimulus(0, 0, 1, 0, 9, 16, "os_run");
    checkOutput("os_pulses", 32'(pulse_count), 32'd1);
    checkOutput("os_edge", 32'(last_pulse - k), 32'd12);
    checkOutput("os_done_held", 32'(done), 32'd1);

    // Periodic, delay 2: five intervals of 8 cycles, then stop
    pulse_count = 0;
    applyStimulus(1, 0, 1, 1, 2, 1, "per_start");
    k = edge_count;
    applyStimulus(0, 0, 1, 0, 0, 40, "per_run");
    checkOutput("per_pulses", 32'(pulse_count), 32'd5);
    checkOutput("per_last_edge", 32'(last_pulse - k), 32'd40);
    applyStimulus(0, 1, 1, 1, 2, 10, "per_stop");
    checkOutput("per_stop_pulses", 32'(pulse_count), 32'd5);

    // Enable low for five cycles stretches a 2-unit one-shot to 13 edges
    pulse_count = 0;
    applyStimulus(1, 0, 1, 0, 2, 1, "gate_start");
    k = edge_count;
    applyStimulus(0, 0, 1, 0, 2, 2, "gate_en1");
    applyStimulus(0, 0, 0, 0, 2, 5, "gate_en0");
    applyStimulus(0, 0, 1, 0, 2, 12, "gate_en2");
    checkOutput("gate_pulses", 32'(pulse_count), 32'd1);
    checkOutput("gate_edge", 32'(last_pulse - k), 32'd13);

    // Zero delay completes immediately
    pulse_count = 0;
    applyStimulus(1, 0, 1, 1, 0, 1, "zero_start");
    k = edge_count;
    applyStimulus(0, 0, 1, 0, 0, 4, "zero_idle");
    checkOutput("zero_pulses", 32'(pulse_count), 32'd1);
    checkOutput("zero_edge", 32'(last_pulse - k), 32'd0);

    // Restart on the terminal tick swallows the pending pulse
    pulse_count = 0;
    applyStimulus(1, 0, 1, 0, 1, 4, "tick_start");
    applyStimulus(1, 0, 1, 0, 5, 3, "tick_restart");
    checkOutput("tick_pulses", 32'(pulse_count), 32'd0);
    checkOutput("tick_remain", 32'(remaining), 32'd5);

    // Asynchronous reset mid-run
    pulse_count = 0;
    applyStimulus(1, 0, 1, 0, 3, 5, "arst_run");
    #2 reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_done", 32'(done), 32'd1);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_pulse", 32'(done_pulse), 32'd0);
    checkOutput("arst_remain", 32'(remaining), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, 3, 20, "arst_after");
    checkOutput("arst_pulses", 32'(pulse_count), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        #2 reset_n = 1'b0;
        modelReset();
        #2 reset_n = 1'b1;
      end
      start    = ($urandom_range(19) == 0);
      stop     = ($urandom_range(39) == 0);
      enable   = ($urandom_range(4) != 0);
      periodic = $urandom_range(1);
      delay    = CW'($urandom_range(5));
      stepCycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_timer_periodic.md
DELAY_TIMER_PERIODIC -- requirements
Module: delay_timer_periodic

Interface
REQ-001 SHALL have parameter TICK_PERIOD, default 500000, clock cycles per delay unit (10 ms at 50 MHz); legal range 1..2^TICK_W.
REQ-002 SHALL have parameter TICK_W, default 19, width of the tick prescaler.
REQ-003 SHALL have parameter CNT_W, default 8, width of the delay/down-counter.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, load delay and begin timing.
REQ-007 SHALL have port stop, input, 1, abort timing without completion.
REQ-008 SHALL have port enable, input, 1, counting qualifier; low freezes the prescaler and down-counter.
REQ-009 SHALL have port periodic, input, 1, sampled with start: 0 one-shot, 1 auto-reload.
REQ-010 SHALL have port delay, input, CNT_W, number of delay units.
REQ-011 SHALL have port done, output, 1, level: high when in IDLE or DONE.
REQ-012 SHALL have port done_pulse, output, 1, one-cycle strobe per completed interval.
REQ-013 SHALL have port busy, output, 1, high in RUN.
REQ-014 SHALL have port remaining, output, CNT_W, current down-counter value.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; all outputs registered or decoded from registered state only.
REQ-016 SHALL apply priority start > stop > tick each cycle.
REQ-017 SHALL, on start with delay!=0 (any state): down-counter=delay, reload register=delay, mode register=periodic, prescaler=0, state RUN.
REQ-018 SHALL, on start with delay==0: down-counter=0, state DONE, done_pulse high next cycle, regardless of periodic.
REQ-019 SHALL increment the prescaler only in RUN with enable high; when prescaler==TICK_PERIOD-1 and enable high, issue a tick: prescaler=0, down-counter decremented.
REQ-020 SHALL make one unit exactly TICK_PERIOD enabled cycles; TICK_PERIOD=1 ticks every enabled cycle.
REQ-021 SHALL, on a tick with down-counter==1 in one-shot mode: down-counter=0, state DONE, done_pulse high for that one following cycle.
REQ-022 SHALL, on a tick with down-counter==1 in periodic mode: down-counter=reload register, remain RUN, done_pulse high one cycle, done stays low.
REQ-023 SHALL, with enable held high from start (sampled at edge k), assert done_pulse (and done for one-shot) after edge k+D*TICK_PERIOD; each enable-low cycle adds exactly one cycle.
REQ-024 SHALL, on stop (no start): state IDLE, down-counter=0, prescaler=0, no done_pulse; stop in IDLE/DONE moves to IDLE.
REQ-025 SHALL, on start during RUN (including the tick cycle), restart cleanly with the new delay and suppress any done_pulse from the aborted interval.
REQ-026 SHALL ignore delay and periodic changes except at start; DONE persists until start or stop.
REQ-027 SHALL never wrap the down-counter below 0 or the prescaler above TICK_PERIOD-1.

Reset
REQ-028 SHALL, while reset_n low, force state IDLE, prescaler=0, down-counter=0, reload=0, mode=0: done=1, done_pulse=0, busy=0, remaining=0.
REQ-029 SHALL abort any interval on reset mid-operation with no done_pulse after release.
REQ-030 SHALL take no action on the first edge after release unless start is high.

Verification (TICK_PERIOD=4, CNT_W=8)
REQ-031 SHALL verify one-shot: start, delay=3, enable=1 -> busy, remaining 3,2,1 at 4-cycle steps; done and done_pulse after edge 12; done stays high.
REQ-032 SHALL verify periodic: start, delay=2, periodic=1 -> done_pulse every 8 cycles for 5 intervals, remaining reloads to 2, done stays low; stop -> IDLE, no pulse.
REQ-033 SHALL verify enable gating: enable low for 5 cycles mid-interval, delay=2 -> done_pulse after edge 13, not 8.
REQ-034 SHALL verify start with delay=0 -> done_pulse next cycle, busy never high; start on the tick cycle with remaining=1 -> no pulse, new delay loaded.
REQ-035 SHALL verify reset_n pulsed low mid-RUN (asynchronously, between edges) -> outputs at reset values immediately, no done_pulse after release.
